// File: rtl/spi_serf.sv
//----------------------------------------------------------------------------
// Module      : spi_serf
// Description : SPI serf (slave). SS_n/SCLK/MOSI are synchronized into the
//               clk domain and edge-detected. Bits are sampled on SCLK rise
//               and shifted in on SCLK fall, MSB first. The transmit word is
//               loaded with wrt while idle. A completed 16-bit frame updates
//               rx_data and pulses rdy.
//               Optional build macro SPI_SERF_FRAME_CHECK_EN adds the frm_err
//               output, which flags frames that end with a wrong bit count.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module spi_serf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic             wrt,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
`ifdef SPI_SERF_FRAME_CHECK_EN
  output logic             frm_err,
`endif
  output logic             busy
);

  // bit counter must hold WIDTH+1 (saturation value)
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  localparam logic [1:0] SYNC   = 2'd0;
  localparam logic [1:0] IDLE   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       settle;
  logic             ss_meta, ss_sync, ss_hist;
  logic             sclk_meta, sclk_sync, sclk_hist;
  logic             mosi_meta, mosi_sync, mosi_hist;
  logic [WIDTH-1:0] shft_reg;
  logic [CW-1:0]    bit_cnt;
  logic             sample;

  logic             ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [CW-1:0]    cnt_nxt;
  logic             sample_nxt;
  logic [WIDTH-1:0] shft_nxt;
  logic [WIDTH-1:0] word_done;
  logic             frame_end, frame_ok;

  // Two-flop synchronizers plus a history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_hist   <= 1'b1;
      sclk_meta <= 1'b1;
      sclk_sync <= 1'b1;
      sclk_hist <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      mosi_hist <= 1'b0;
    end else begin
      ss_meta   <= SS_n;
      ss_sync   <= ss_meta;
      ss_hist   <= ss_sync;
      sclk_meta <= SCLK;
      sclk_sync <= sclk_meta;
      sclk_hist <= sclk_sync;
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
      mosi_hist <= mosi_sync;
    end
  end

  assign ss_fall   = ss_hist & ~ss_sync;
  assign ss_rise   = ~ss_hist & ss_sync;
  assign sclk_rise = ~sclk_hist & sclk_sync;
  assign sclk_fall = sclk_hist & ~sclk_sync;

  // Counts the clocks needed for the synchronizer to flush its reset values,
  // so SYNC only trusts SS_n once it reflects the real pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= 2'd0;
    end else if (settle != 2'd2) begin
      settle <= settle + 2'd1;
    end
  end

  // Per-cycle frame update: SCLK edge is applied first so a coincident
  // SS_n rise sees the final bit
  always_comb begin
    cnt_nxt    = bit_cnt;
    sample_nxt = sample;
    shft_nxt   = shft_reg;
    if (state == ACTIVE) begin
      if (sclk_rise) begin
        sample_nxt = mosi_hist;
        if (bit_cnt != CNT_SAT) begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      // a fall with no rise yet in this frame is the front porch
      if (sclk_fall && (bit_cnt != '0)) begin
        shft_nxt = {shft_reg[WIDTH-2:0], sample};
      end
    end
  end

  assign word_done = {shft_nxt[WIDTH-2:0], sample_nxt};
  assign frame_end = (state == ACTIVE) && ss_rise;
  assign frame_ok  = frame_end && (cnt_nxt == CNT_FULL);

  // Frame state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SYNC;
    end else begin
      case (state)
        SYNC:    if ((settle == 2'd2) && ss_sync) state <= IDLE;
        IDLE:    if (ss_fall) state <= ACTIVE;
        ACTIVE:  if (ss_rise) state <= IDLE;
        default: state <= SYNC;
      endcase
    end
  end

  // Shift register, bit counter and sample bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shft_reg <= '0;
      bit_cnt  <= '0;
      sample   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wrt) shft_reg <= tx_data;
          if (ss_fall) bit_cnt <= '0;
        end
        ACTIVE: begin
          bit_cnt <= cnt_nxt;
          sample  <= sample_nxt;
          // a good frame leaves the full word in place so it echoes back
          shft_reg <= frame_ok ? word_done : shft_nxt;
        end
        default: ;
      endcase
    end
  end

  // Received word and completion strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= '0;
      rdy     <= 1'b0;
`ifdef SPI_SERF_FRAME_CHECK_EN
      frm_err <= 1'b0;
`endif
    end else begin
      rdy <= frame_ok;
      if (frame_ok) rx_data <= word_done;
`ifdef SPI_SERF_FRAME_CHECK_EN
      frm_err <= frame_end && (cnt_nxt != CNT_FULL);
`endif
    end
  end

  assign MISO = shft_reg[WIDTH-1];
  assign busy = (state == ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_spi_serf.sv
//----------------------------------------------------------------------------
// Module      : tb_spi_serf
// Description : Self-checking bench for spi_serf. A monarch task drives
//               frames at SCLK = clk/32; a word-level model tracks the word
//               the serf holds and the last received word.
//----------------------------------------------------------------------------
`default_nettype none

module tb_spi_serf;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI, MISO, wrt, rdy, busy;
  logic [15:0] tx_data, rx_data;
`ifdef SPI_SERF_FRAME_CHECK_EN
  logic        frm_err;
`endif

  spi_serf #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .wrt     (wrt),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rdy     (rdy),
`ifdef SPI_SERF_FRAME_CHECK_EN
    .frm_err (frm_err),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          rdy_seen    = 0;
  int          err_seen    = 0;
  logic        chk_en      = 1'b0;
  logic [15:0] exp_rx      = 16'h0000;  // model: last good received word
  logic [15:0] exp_shift   = 16'h0000;  // model: word the serf will send
  logic [15:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse counters and the continuous compare between frames
  always @(negedge clk) begin
    if (rdy === 1'b1) rdy_seen++;
`ifdef SPI_SERF_FRAME_CHECK_EN
    if (frm_err === 1'b1) err_seen++;
`endif
    if (chk_en) begin
      check("rx_data_hold", {16'h0, rx_data}, {16'h0, exp_rx});
      check("rdy_quiet", {31'h0, rdy}, 32'h0);
    end
  end

  task automatic load(input logic [15:0] w);
    tx_data = w;
    wrt     = 1'b1;
    tick(1);
    wrt     = 1'b0;
    tx_data = 16'h0;
    check("miso_after_wrt", {31'h0, MISO}, {31'h0, w[15]});
    exp_shift = w;
    tick(2);
  endtask

  // Monarch frame: nrise SCLK rises; optional reset after rise rst_at,
  // optional wrt of 16'hFFFF after rise wrt_at, optional SS_n rise together
  // with the last SCLK rise.
  task automatic xfer(input logic [15:0] word, input int nrise, input int rst_at,
                      input int wrt_at, input bit simul, output logic [15:0] rdo);
    int          r0, e0;
    logic [15:0] ret_exp, sh;
    logic [31:0] stream;
    bit          did_rst;
    r0 = rdy_seen; e0 = err_seen; ret_exp = exp_shift; did_rst = 1'b0;
    rdo = 16'h0; sh = word;
    SS_n = 1'b0;
    tick(16);
    check("busy_start", {31'h0, busy}, 32'h1);
    if (nrise > 0) begin
      SCLK = 1'b0;
      MOSI = sh[15];
    end
    for (int i = 0; i < nrise; i++) begin
      tick(16);
      SCLK = 1'b1;
      rdo  = {rdo[14:0], MISO};
      if (simul && (i == nrise - 1)) begin
        chk_en = 1'b0;
        SS_n   = 1'b1;
      end
      if (i + 1 == wrt_at) begin
        wrt = 1'b1; tx_data = 16'hFFFF;
        tick(1);
        wrt = 1'b0; tx_data = 16'h0;
      end
      if (i + 1 == rst_at) begin
        chk_en = 1'b0; exp_rx = 16'h0; exp_shift = 16'h0;
        #2 rst = 1'b1;
        #1;
        check("rst_rx_data", {16'h0, rx_data}, 32'h0);
        check("rst_rdy", {31'h0, rdy}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_miso", {31'h0, MISO}, 32'h0);
        tick(2);
        rst = 1'b0; did_rst = 1'b1; chk_en = 1'b1;
      end
      if (did_rst && (i == rst_at + 2)) check("busy_after_rst", {31'h0, busy}, 32'h0);
      tick(16);
      if (i < nrise - 1) begin
        SCLK = 1'b0;
        sh   = sh << 1;
        MOSI = sh[15];
      end
    end
    if (!simul) begin
      chk_en = 1'b0;
      SS_n   = 1'b1;
    end
    tick(8);
    check("busy_end", {31'h0, busy}, 32'h0);
    if (did_rst) begin
      check("rdy_pulses", rdy_seen - r0, 32'd0);
    end else if (nrise == 16) begin
      check("rdy_pulses", rdy_seen - r0, 32'd1);
      check("miso_return", {16'h0, rdo}, {16'h0, ret_exp});
      exp_rx    = word;
      exp_shift = word;
    end else begin
      check("rdy_pulses", rdy_seen - r0, 32'd0);
      // each fall after the first rise shifts one sent bit in, MSB first
      if (nrise > 0) begin
        stream    = {exp_shift, word} >> (17 - nrise);
        exp_shift = stream[15:0];
      end
    end
`ifdef SPI_SERF_FRAME_CHECK_EN
    check("frm_err_pulses", err_seen - e0, (!did_rst && nrise != 16) ? 32'd1 : 32'd0);
`endif
    check("rx_data_after", {16'h0, rx_data}, {16'h0, exp_rx});
    chk_en = 1'b1;
    tick(8);
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; wrt = 1'b0; tx_data = 16'h0;
    tick(3);
    check("reset_rx_data", {16'h0, rx_data}, 32'h0);
    check("reset_rdy", {31'h0, rdy}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_miso", {31'h0, MISO}, 32'h0);
    rst = 1'b0;
    tick(5);
    chk_en = 1'b1;

    // basic transfer and echo
    load(16'h006A);
    xfer(16'h8F00, 16, -1, -1, 1'b0, rd);
    check("lit_rd_006A", {16'h0, rd}, 32'h006A);
    check("lit_rx_8F00", {16'h0, rx_data}, 32'h8F00);
    xfer(16'h1234, 16, -1, -1, 1'b0, rd);
    check("lit_rd_echo", {16'h0, rd}, 32'h8F00);
    check("lit_rx_1234", {16'h0, rx_data}, 32'h1234);

    // aborted frame after 8 SCLK cycles leaves a partially shifted word
    xfer(16'hBEEF, 8, -1, -1, 1'b0, rd);
    check("lit_rx_keep", {16'h0, rx_data}, 32'h1234);
    xfer(16'h0F0F, 16, -1, -1, 1'b0, rd);
    check("lit_rd_partial", {16'h0, rd}, 32'h1A5F);

    // reset after 5 bits with SS_n held low
    xfer(16'h5555, 16, 5, -1, 1'b0, rd);
    xfer(16'hA5C3, 16, -1, -1, 1'b0, rd);
    check("lit_rx_A5C3", {16'h0, rx_data}, 32'hA5C3);
    check("lit_rd_zero", {16'h0, rd}, 32'h0000);

    // wrt mid-frame ignored
    load(16'hC001);
    xfer(16'h7E81, 16, -1, 4, 1'b0, rd);
    check("lit_rd_C001", {16'h0, rd}, 32'hC001);

    // boundary bit counts: 0 and 17 are discarded
    xfer(16'h1111, 0, -1, -1, 1'b0, rd);
    xfer(16'h3C3C, 17, -1, -1, 1'b0, rd);
    check("lit_rx_7E81", {16'h0, rx_data}, 32'h7E81);
    xfer(16'h0000, 16, -1, -1, 1'b0, rd);
    check("lit_rd_3C3C", {16'h0, rd}, 32'h3C3C);

    // SS_n rise coincident with the last SCLK rise
    xfer(16'h9669, 16, -1, -1, 1'b1, rd);
    check("lit_rx_9669", {16'h0, rx_data}, 32'h9669);

    chk_en = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
